sim_run_controller: RTL and testbench



---
 rtl/sim_ctrl_pkg.sv | 14 +
 rtl/hart_halt_latch.sv | 42 ++++
 rtl/sim_run_controller.sv | 150 +++++++++++++++
 tb/tb_sim_run_controller.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/sim_ctrl_pkg.sv
// sim_ctrl_pkg: shared run-controller state encoding, default pass code and retire popcount
package sim_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, RESET_HOLD, RUN, DONE} state_t;

    localparam logic [31:0] DEFAULT_PASS_CODE = 32'd1;

    // Counts set bits of up to eight per-hart retire strobes (callers zero-extend).
    function automatic logic [3:0] popcount(input logic [7:0] v);
        popcount = '0;
        for (int i = 0; i < 8; i++) popcount = popcount + {3'b000, v[i]};
    endfunction

endpackage

// File: rtl/hart_halt_latch.sv
// hart_halt_latch: captures the first halt code of one hart during RUN and flags whether it is the pass code
module hart_halt_latch
    import sim_ctrl_pkg::*;
#(
    parameter int                 CODE_W    = 32,
    parameter logic [CODE_W-1:0]  PASS_CODE = CODE_W'(DEFAULT_PASS_CODE)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              enable,
    input  logic              halt_valid,
    input  logic [CODE_W-1:0] halt_code,
    output logic              latched,
    output logic              latched_nxt,
    output logic              code_ok_nxt
);

    logic [CODE_W-1:0] code;
    logic [CODE_W-1:0] code_nxt;
    logic              take;

    // Only the first halt of a run is taken; the look-ahead view lets the top decide completion this cycle.
    always_comb begin
        take        = enable && halt_valid && !latched;
        latched_nxt = latched || take;
        code_nxt    = take ? halt_code : code;
        code_ok_nxt = code_nxt == PASS_CODE;
    end

    // Mask bit and code register, wiped on reset or at the start of a new run.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            latched <= 1'b0;
            code    <= '0;
        end else if (take) begin
            latched <= 1'b1;
            code    <= halt_code;
        end
    end

endmodule

// File: rtl/sim_run_controller.sv
// sim_run_controller: reset sequencing, bounded run, cycle/instret counting and multi-hart pass/fail/timeout; optional RUN_WATCHDOG_EN adds a no-retire hang detector
module sim_run_controller
    import sim_ctrl_pkg::*;
#(
    parameter int                 NUM_HARTS    = 1,
    parameter int                 RESET_CYCLES = 2,
    parameter int                 MAX_CYCLES   = 20,
    parameter int                 CNT_W        = 32,
    parameter int                 CODE_W       = 32,
    parameter logic [CODE_W-1:0]  PASS_CODE    = CODE_W'(DEFAULT_PASS_CODE),
    parameter int                 WDOG_CYCLES  = 16
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start,
    output logic                        core_reset,
    input  logic [NUM_HARTS-1:0]        retire_valid,
    input  logic [NUM_HARTS-1:0]        halt_valid,
    input  logic [NUM_HARTS*CODE_W-1:0] halt_code,
    output logic                        running,
    output logic                        done,
    output logic                        pass,
    output logic                        timeout,
    output logic                        hang,
    output logic [CNT_W-1:0]            cycle_count,
    output logic [CNT_W-1:0]            instret,
    output logic [NUM_HARTS-1:0]        halted_mask
);

    localparam int HW = $clog2(RESET_CYCLES + 1);

    state_t              state;
    state_t              state_nxt;
    logic [HW-1:0]       hold_cnt;
    logic [NUM_HARTS-1:0] mask_nxt;
    logic [NUM_HARTS-1:0] ok_nxt;
    logic                in_run;
    logic                go;
    logic                complete;
    logic                timed_out;
    logic                hung;
    logic                finish;
    logic [CNT_W:0]      cyc_sum;
    logic [CNT_W:0]      ret_sum;

`ifdef RUN_WATCHDOG_EN
    localparam int WW = $clog2(WDOG_CYCLES + 1);
    logic [WW-1:0] wdog_cnt;
    logic          hang_q;
`endif

    genvar h;
    generate
        for (h = 0; h < NUM_HARTS; h++) begin : g_hart
            hart_halt_latch #(
                .CODE_W    (CODE_W),
                .PASS_CODE (PASS_CODE)
            ) u_latch (
                .clock       (clock),
                .reset       (reset),
                .clear       (go),
                .enable      (in_run),
                .halt_valid  (halt_valid[h]),
                .halt_code   (halt_code[h*CODE_W +: CODE_W]),
                .latched     (halted_mask[h]),
                .latched_nxt (mask_nxt[h]),
                .code_ok_nxt (ok_nxt[h])
            );
        end
    endgenerate

    // Run events and saturating counter sums; completion outranks hang, which outranks timeout.
    always_comb begin
        in_run    = state == RUN;
        go        = start && (state == IDLE || state == DONE);
        complete  = in_run && &mask_nxt;
        timed_out = in_run && cycle_count == CNT_W'(MAX_CYCLES - 1);
`ifdef RUN_WATCHDOG_EN
        hung      = in_run && retire_valid == '0 && wdog_cnt == WW'(WDOG_CYCLES - 1);
`else
        hung      = 1'b0;
`endif
        finish    = complete || hung || timed_out;
        cyc_sum   = {1'b0, cycle_count} + (CNT_W+1)'(1);
        ret_sum   = {1'b0, instret} + (CNT_W+1)'(popcount(8'(retire_valid)));
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:       state_nxt = start ? RESET_HOLD : IDLE;
            RESET_HOLD: state_nxt = hold_cnt == HW'(RESET_CYCLES - 1) ? RUN : RESET_HOLD;
            RUN:        state_nxt = finish ? DONE : RUN;
            DONE:       state_nxt = start ? RESET_HOLD : DONE;
            default:    state_nxt = IDLE;
        endcase
    end

    // Decoded FSM outputs.
    always_comb begin
        core_reset = state != RUN;
        running    = state == RUN;
        done       = state == DONE;
    end

    // Hold counter, RUN counters and final status; all cleared on reset or a new run, frozen in DONE.
    always_ff @(posedge clock) begin
        if (reset || go) begin
            hold_cnt    <= '0;
            cycle_count <= '0;
            instret     <= '0;
            pass        <= 1'b0;
            timeout     <= 1'b0;
`ifdef RUN_WATCHDOG_EN
            wdog_cnt    <= '0;
            hang_q      <= 1'b0;
`endif
        end else begin
            if (state == RESET_HOLD) hold_cnt <= hold_cnt + HW'(1);
            if (in_run) begin
                cycle_count <= cyc_sum[CNT_W] ? '1 : cyc_sum[CNT_W-1:0];
                instret     <= ret_sum[CNT_W] ? '1 : ret_sum[CNT_W-1:0];
`ifdef RUN_WATCHDOG_EN
                wdog_cnt    <= |retire_valid ? '0 : wdog_cnt + WW'(1);
`endif
                if (finish) begin
                    pass    <= complete && &ok_nxt;
                    timeout <= !complete && !hung && timed_out;
`ifdef RUN_WATCHDOG_EN
                    hang_q  <= !complete && hung;
`endif
                end
            end
        end
    end

`ifdef RUN_WATCHDOG_EN
    assign hang = hang_q;
`else
    assign hang = 1'b0;
`endif

endmodule

// File: tb/tb_sim_run_controller.sv
// tb_sim_run_controller: directed checks of reset sequencing, halt latching, timeout and counters (watchdog when RUN_WATCHDOG_EN)
module tb_sim_run_controller;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic        a_start = 0, a_ret = 0, a_hv = 0;
    logic [31:0] a_hc = 0;
    logic        a_cr, a_run, a_done, a_pass, a_to, a_hang, a_mask;
    logic [31:0] a_cyc, a_ins;

    logic        b_start = 0;
    logic [1:0]  b_ret = 0, b_hv = 0;
    logic [63:0] b_hc = 0;
    logic        b_cr, b_run, b_done, b_pass, b_to, b_hang;
    logic [1:0]  b_mask;
    logic [31:0] b_cyc, b_ins;

    sim_run_controller #(.NUM_HARTS(1), .RESET_CYCLES(2), .MAX_CYCLES(20), .WDOG_CYCLES(64)) dut_a (
        .clock(clock), .reset(reset), .start(a_start), .core_reset(a_cr),
        .retire_valid(a_ret), .halt_valid(a_hv), .halt_code(a_hc),
        .running(a_run), .done(a_done), .pass(a_pass), .timeout(a_to), .hang(a_hang),
        .cycle_count(a_cyc), .instret(a_ins), .halted_mask(a_mask)
    );

    sim_run_controller #(.NUM_HARTS(2), .RESET_CYCLES(2), .MAX_CYCLES(20), .WDOG_CYCLES(64)) dut_b (
        .clock(clock), .reset(reset), .start(b_start), .core_reset(b_cr),
        .retire_valid(b_ret), .halt_valid(b_hv), .halt_code(b_hc),
        .running(b_run), .done(b_done), .pass(b_pass), .timeout(b_to), .hang(b_hang),
        .cycle_count(b_cyc), .instret(b_ins), .halted_mask(b_mask)
    );

`ifdef RUN_WATCHDOG_EN
    logic        w_start = 0, w_ret = 0, w_hv = 0;
    logic [31:0] w_hc = 0;
    logic        w_cr, w_run, w_done, w_pass, w_to, w_hang, w_mask;
    logic [31:0] w_cyc, w_ins;

    sim_run_controller #(.NUM_HARTS(1), .RESET_CYCLES(2), .MAX_CYCLES(40), .WDOG_CYCLES(16)) dut_w (
        .clock(clock), .reset(reset), .start(w_start), .core_reset(w_cr),
        .retire_valid(w_ret), .halt_valid(w_hv), .halt_code(w_hc),
        .running(w_run), .done(w_done), .pass(w_pass), .timeout(w_to), .hang(w_hang),
        .cycle_count(w_cyc), .instret(w_ins), .halted_mask(w_mask)
    );
`endif

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    initial begin
        step(2);
        reset = 1'b0;
        check("rst core_reset", a_cr, 1);
        check("rst running", a_run, 0);
        check("rst done", a_done, 0);
        check("rst pass/to/hang", {a_pass, a_to, a_hang}, 0);
        check("rst counters", a_cyc | a_ins, 0);
        check("rst mask", b_mask, 0);

        // single hart, pass code at RUN cycle 10
        a_start = 1; step(1); a_start = 0;
        check("hold1 core_reset", a_cr, 1);
        step(1);
        check("hold2 core_reset", a_cr, 1);
        check("hold2 running", a_run, 0);
        step(1);
        check("run core_reset", a_cr, 0);
        check("run running", a_run, 1);
        step(10);
        a_hv = 1; a_hc = 1; step(1); a_hv = 0;
        check("pass done", a_done, 1);
        check("pass pass", a_pass, 1);
        check("pass timeout", a_to, 0);
        check("pass cycles", a_cyc, 11);
        check("pass core_reset", a_cr, 1);

        // restart from DONE, fail code
        a_start = 1; step(1); a_start = 0;
        check("restart done", a_done, 0);
        check("restart cycles", a_cyc, 0);
        check("restart mask", a_mask, 0);
        step(2);
        a_hv = 1; a_hc = 5; step(1); a_hv = 0;
        check("fail done", a_done, 1);
        check("fail pass", a_pass, 0);
        check("fail timeout", a_to, 0);
        check("fail cycles", a_cyc, 1);

        // timeout; retires outside RUN ignored
        a_ret = 1;
        a_start = 1; step(1); a_start = 0;
        step(2);
        step(19);
        check("to running", a_run, 1);
        step(1);
        check("to done", a_done, 1);
        check("to timeout", a_to, 1);
        check("to pass", a_pass, 0);
        check("to hang", a_hang, 0);
        check("to cycles", a_cyc, 20);
        check("to instret", a_ins, 20);
        a_hv = 1; a_hc = 1; step(1); a_hv = 0; a_ret = 0;
        check("done frozen instret", a_ins, 20);
        check("done halt ignored", a_mask, 0);

        // halt in the last budgeted cycle wins over timeout
        a_start = 1; step(1); a_start = 0;
        step(2);
        step(19);
        a_hv = 1; a_hc = 1; step(1); a_hv = 0;
        check("last pass", a_pass, 1);
        check("last timeout", a_to, 0);
        check("last cycles", a_cyc, 20);

        // two harts, repeat halt from hart0 ignored
        b_start = 1; step(1); b_start = 0;
        step(2);
        step(4);
        b_hv = 2'b01; b_hc = {32'd0, 32'd1}; step(1); b_hv = 0;
        check("mh mask0", b_mask, 2'b01);
        check("mh not done", b_done, 0);
        step(1);
        b_hv = 2'b01; b_hc = {32'd0, 32'd7}; step(1); b_hv = 0;
        step(2);
        b_hv = 2'b10; b_hc = {32'd1, 32'd0}; step(1); b_hv = 0;
        check("mh done", b_done, 1);
        check("mh pass", b_pass, 1);
        check("mh mask", b_mask, 2'b11);
        check("mh cycles", b_cyc, 10);

        // instret accumulation, start ignored in RUN, mid-run reset
        b_start = 1; step(1); b_start = 0;
        step(2);
        b_ret = 2'b11; b_hv = 2'b01; b_hc = {32'd0, 32'd3}; step(1); b_hv = 0;
        check("ir mask", b_mask, 2'b01);
        step(1);
        b_start = 1; step(1); b_start = 0;
        check("ir start ignored", b_run, 1);
        check("ir cycles3", b_cyc, 3);
        check("ir instret3", b_ins, 6);
        step(2);
        b_ret = 2'b01; step(3); b_ret = 0;
        check("ir instret", b_ins, 13);
        check("ir cycles", b_cyc, 8);
        reset = 1; step(1); reset = 0;
        check("mid rst core_reset", b_cr, 1);
        check("mid rst running", b_run, 0);
        check("mid rst counters", b_cyc | b_ins, 0);
        check("mid rst mask", b_mask, 0);

`ifdef RUN_WATCHDOG_EN
        w_start = 1; step(1); w_start = 0;
        step(2);
        w_ret = 1; step(5); w_ret = 0;
        step(15);
        check("wd running", w_run, 1);
        step(1);
        check("wd done", w_done, 1);
        check("wd hang", w_hang, 1);
        check("wd pass", w_pass, 0);
        check("wd timeout", w_to, 0);
        check("wd cycles", w_cyc, 21);
        w_start = 1; step(1); w_start = 0;
        check("wd restart hang", w_hang, 0);
        check("wd restart cycles", w_cyc, 0);
        step(2);
        w_hv = 1; w_hc = 1; step(1); w_hv = 0;
        check("wd restart pass", w_pass, 1);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
